// File: rtl/fetch_queue.sv
// Fetch stage: drives I-cache PCs and buffers returned instructions
// in a small FIFO drained by decode; redirects flush and restart fetch.
module fetch_queue #(
   parameter int ADDR_WIDTH = 26,
   parameter int DEPTH      = 4,
   parameter int RESET_PC   = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_redirect_valid,
   input  logic [ADDR_WIDTH-1:0]     i_redirect_pc,
   output logic [ADDR_WIDTH-1:0]     o_pc_current,
   output logic [ADDR_WIDTH-1:0]     o_pc_next,
   input  logic                      i_cache_valid,
   input  logic [31:0]               i_cache_data,
   output logic                      o_inst_valid,
   output logic [31:0]               o_inst_data,
   output logic [ADDR_WIDTH-1:0]     o_inst_pc,
   input  logic                      i_inst_ready,
   output logic [$clog2(DEPTH):0]    o_count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] RST_RAW = ADDR_WIDTH'(RESET_PC);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_inc;
   logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
   logic [PW:0]           count_q, count_d;
   logic [31:0]           mem_data_q [DEPTH];
   logic [ADDR_WIDTH-1:0] mem_pc_q   [DEPTH];
   logic                  full, push, pop;

   assign full = (count_q == FULL_CNT);
   // Decode ready never feeds push, so a full queue stalls fetch
   // even when the head drains in the same cycle.
   assign push = i_cache_valid & ~full & ~i_redirect_valid;
   assign pop  = o_inst_valid & i_inst_ready & ~i_redirect_valid;

   assign pc_inc = pc_q + ADDR_WIDTH'(4);

   always_comb begin
      pc_d = pc_q;
      unique case (1'b1)
         i_redirect_valid: pc_d = {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00};
         push:             pc_d = pc_inc;
         default:          pc_d = pc_q;
      endcase
   end

   always_comb begin
      count_d = count_q;
      if (i_redirect_valid) begin
         count_d = '0;
      end else if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q     <= {RST_RAW[ADDR_WIDTH-1:2], 2'b00};
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         pc_q    <= pc_d;
         count_q <= count_d;
         if (i_redirect_valid) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         mem_data_q[wr_ptr_q] <= i_cache_data;
         mem_pc_q[wr_ptr_q]   <= pc_q;
      end
   end

   assign o_pc_current = pc_q;
   assign o_pc_next    = pc_d;
   assign o_inst_valid = (count_q != '0);
   assign o_inst_data  = mem_data_q[rd_ptr_q];
   assign o_inst_pc    = mem_pc_q[rd_ptr_q];
   assign o_count      = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: vector table for fetch/FIFO
// behaviour plus a steady push/pop run across pointer wrap.
module tb_fetch_queue;

   localparam int AW = 26;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          rv;
   logic [AW-1:0] rpc;
   logic [AW-1:0] pc_cur, pc_nx;
   logic          cv;
   logic [31:0]   cd;
   logic          iv;
   logic [31:0]   idata;
   logic [AW-1:0] ipc;
   logic          rdy;
   logic [2:0]    cnt;

   int total = 0;
   int bad = 0;

   fetch_queue #(
      .ADDR_WIDTH(AW),
      .DEPTH(4),
      .RESET_PC('h100)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .i_redirect_valid(rv),
      .i_redirect_pc(rpc),
      .o_pc_current(pc_cur),
      .o_pc_next(pc_nx),
      .i_cache_valid(cv),
      .i_cache_data(cd),
      .o_inst_valid(iv),
      .o_inst_data(idata),
      .o_inst_pc(ipc),
      .i_inst_ready(rdy),
      .o_count(cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          rst_n;
      logic          rv;
      logic [AW-1:0] rpc;
      logic          cv;
      logic          rdy;
      logic          chk;
      logic [AW-1:0] e_pc;
      logic [AW-1:0] e_nx;
      logic          e_v;
      logic [AW-1:0] e_hpc;
      logic [2:0]    e_cnt;
   } vec_t;

   vec_t vq[$];

   function automatic logic [31:0] dat(input logic [AW-1:0] pc);
      return 32'hA500_0000 ^ {6'h0, pc};
   endfunction

   function automatic vec_t mk(
      input logic rs, input logic r, input logic [AW-1:0] rp,
      input logic c, input logic rd, input logic ck,
      input logic [AW-1:0] epc, input logic [AW-1:0] enx,
      input logic ev, input logic [AW-1:0] ehpc, input logic [2:0] ecnt);
      vec_t v;
      v.rst_n = rs; v.rv = r; v.rpc = rp; v.cv = c; v.rdy = rd;
      v.chk = ck; v.e_pc = epc; v.e_nx = enx; v.e_v = ev;
      v.e_hpc = ehpc; v.e_cnt = ecnt;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [AW-1:0] epc,
                            input logic [AW-1:0] enx, input logic ev,
                            input logic [AW-1:0] ehpc, input logic [2:0] ecnt);
      chk({tag, ".pc_cur"}, 32'(pc_cur), 32'(epc));
      chk({tag, ".pc_next"}, 32'(pc_nx), 32'(enx));
      chk({tag, ".valid"}, 32'(iv), 32'(ev));
      chk({tag, ".count"}, 32'(cnt), 32'(ecnt));
      if (ev) begin
         chk({tag, ".head_pc"}, 32'(ipc), 32'(ehpc));
         chk({tag, ".head_data"}, idata, dat(ehpc));
      end
   endtask

   initial begin
      logic [AW-1:0] hp;
      logic [AW-1:0] cp;

      rst_n = 1'b0; rv = 1'b0; rpc = '0; cv = 1'b0; cd = '0; rdy = 1'b0;

      // reset
      vq.push_back(mk(0,0,0,0,0, 0, 0,0,0,0,0));
      // streaming hits, ready=1
      vq.push_back(mk(1,0,0,1,1, 1, 'h100,'h104,0,0,0));
      vq.push_back(mk(1,0,0,1,1, 1, 'h104,'h108,1,'h100,1));
      // stall decode, fill up
      vq.push_back(mk(1,0,0,1,0, 1, 'h108,'h10C,1,'h104,1));
      vq.push_back(mk(1,0,0,1,0, 1, 'h10C,'h110,1,'h104,2));
      vq.push_back(mk(1,0,0,1,0, 1, 'h110,'h114,1,'h104,3));
      // full: hit + ready still holds pc
      vq.push_back(mk(1,0,0,1,1, 1, 'h114,'h114,1,'h104,4));
      vq.push_back(mk(1,0,0,1,0, 1, 'h114,'h118,1,'h108,3));
      vq.push_back(mk(1,0,0,0,1, 1, 'h118,'h118,1,'h108,4));
      // redirect with pending push and pop
      vq.push_back(mk(1,1,'h3FF,1,1, 1, 'h118,'h3FC,1,'h10C,3));
      vq.push_back(mk(1,0,0,0,1, 1, 'h3FC,'h3FC,0,0,0));
      // miss stall
      vq.push_back(mk(1,0,0,0,1, 1, 'h3FC,'h3FC,0,0,0));
      vq.push_back(mk(1,0,0,0,1, 1, 'h3FC,'h3FC,0,0,0));
      vq.push_back(mk(1,0,0,0,1, 1, 'h3FC,'h3FC,0,0,0));
      vq.push_back(mk(1,0,0,1,0, 1, 'h3FC,'h400,0,0,0));
      vq.push_back(mk(1,0,0,0,0, 1, 'h400,'h400,1,'h3FC,1));
      vq.push_back(mk(1,0,0,0,1, 1, 'h400,'h400,1,'h3FC,1));
      vq.push_back(mk(1,0,0,0,1, 1, 'h400,'h400,0,0,0));
      // address wrap at top of space
      vq.push_back(mk(1,1,'h3FFFFFB,0,0, 1, 'h400,'h3FFFFF8,0,0,0));
      vq.push_back(mk(1,0,0,1,0, 1, 'h3FFFFF8,'h3FFFFFC,0,0,0));
      vq.push_back(mk(1,0,0,1,0, 1, 'h3FFFFFC,'h0,1,'h3FFFFF8,1));
      vq.push_back(mk(1,0,0,0,1, 1, 'h0,'h0,1,'h3FFFFF8,2));
      vq.push_back(mk(1,0,0,0,1, 1, 'h0,'h0,1,'h3FFFFFC,1));
      vq.push_back(mk(1,0,0,0,1, 1, 'h0,'h0,0,0,0));
      // reset beats redirect and push
      vq.push_back(mk(0,1,'h500,1,1, 1, 'h0,'h500,0,0,0));
      vq.push_back(mk(1,0,0,0,0, 1, 'h100,'h100,0,0,0));

      @(negedge clk);
      for (int i = 0; i < vq.size(); i++) begin
         rst_n = vq[i].rst_n;
         rv    = vq[i].rv;
         rpc   = vq[i].rpc;
         cv    = vq[i].cv;
         rdy   = vq[i].rdy;
         cd    = vq[i].cv ? dat(vq[i].e_pc) : 32'h0;
         #1;
         if (vq[i].chk)
            check_all($sformatf("v%0d", i), vq[i].e_pc, vq[i].e_nx,
                      vq[i].e_v, vq[i].e_hpc, vq[i].e_cnt);
         @(negedge clk);
      end

      // fill two entries, then steady push+pop across pointer wrap
      rv = 1'b0; rdy = 1'b0; cv = 1'b1;
      cd = dat('h100);
      @(negedge clk);
      cd = dat('h104);
      @(negedge clk);
      rdy = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cp = AW'('h108 + 4 * i);
         hp = AW'('h100 + 4 * i);
         cd = dat(cp);
         #1;
         check_all($sformatf("pp%0d", i), cp, cp + AW'(4), 1'b1, hp, 3'd2);
         @(negedge clk);
      end

      cv = 1'b0;
      #1;
      check_all("drain0", AW'('h158), AW'('h158), 1'b1, AW'('h150), 3'd2);
      @(negedge clk);
      #1;
      check_all("drain1", AW'('h158), AW'('h158), 1'b1, AW'('h154), 3'd1);
      @(negedge clk);
      #1;
      check_all("drain2", AW'('h158), AW'('h158), 1'b0, AW'(0), 3'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Fetch stage that drives the instruction cache request PCs and captures the instructions the cache returns.
- Holds the architectural fetch PC and computes the next fetch PC (sequential or redirect).
- Buffers hit instructions together with their PCs in a small FIFO that decode drains with a valid/ready handshake.
- A redirect from branch resolution or exception flushes the FIFO and restarts fetch.

Parameters:
- ADDR_WIDTH, 26: byte-address width of every PC.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- RESET_PC, 0: fetch PC loaded on reset; word-aligned.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- i_redirect_valid  in  1  flush and redirect fetch this cycle
- i_redirect_pc  in  ADDR_WIDTH  redirect target
- o_pc_current  out  ADDR_WIDTH  PC the cache is returning data for this cycle
- o_pc_next  out  ADDR_WIDTH  PC the cache reads on the coming edge (combinational)
- i_cache_valid  in  1  cache hit for o_pc_current
- i_cache_data  in  32  instruction at o_pc_current
- o_inst_valid  out  1  FIFO head valid
- o_inst_data  out  32  FIFO head instruction
- o_inst_pc  out  ADDR_WIDTH  FIFO head PC
- i_inst_ready  in  1  decode consumes head
- o_count  out  log2(DEPTH)+1  occupancy, for debug and perf counters

Behaviour:
- Reset (rst_n=0 at posedge):
  - pc_current = RESET_PC with low 2 bits cleared.
  - FIFO count, read pointer and write pointer = 0.
  - o_inst_valid = 0.
  - Reset has priority over redirect, push and pop; any in-flight request is dropped.
- Push (push = i_cache_valid & ~full & ~i_redirect_valid):
  - Writes {i_cache_data, o_pc_current} at the write pointer.
  - Sets pc_current <= pc_current+4.
- o_pc_next, combinational, in priority order:
  - i_redirect_valid: {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - push: pc_current+4.
  - otherwise: pc_current (holds the cache index stable during a miss or a full stall).
- pc_current <= o_pc_next every cycle when not in reset; o_pc_current = pc_current.
- PC arithmetic is modulo 2^ADDR_WIDTH: max word address + 4 wraps to 0.
- Pop: pop = o_inst_valid & i_inst_ready.
  - Advances the read pointer; head outputs reflect the new entry the next cycle.
- FIFO output and bypass:
  - o_inst_valid = (count != 0).
  - Head data and PC are driven from storage. There is no bypass: a push is first visible on the cycle after it is written.
- Full (count == DEPTH):
  - No push, even with a same-cycle pop. Decode ready must not feed the PC path.
  - The fetch PC holds; the cache keeps hitting on the same PC and the data is refetched next cycle.
- Empty: a pop is ignored because o_inst_valid = 0.
- Simultaneous push and pop when not full: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Redirect (i_redirect_valid=1):
  - At the edge: count <= 0, both pointers <= 0, pc_current <= aligned target.
  - Same-cycle push and pop are suppressed; the head is not consumed.
  - o_inst_valid = 0 the following cycle.
- Redirect while the cache is mid-refill:
  - pc_next changes immediately. The cache completes its refill for the old line, then misses or hits on the new PC.
  - No instruction for the old PC is ever enqueued after the redirect.
- No state machine beyond the PC and FIFO registers. Throughput is 1 instruction per cycle while hitting and not full.

Test Plan:
- Reset with RESET_PC=0x100, cache always hits, decode always ready → o_pc_current sequence 0x100, 0x104, 0x108. o_inst_valid first high one cycle after the first hit. Head PCs 0x100, 0x104 in order, 1 per cycle.
- Decode ready=0, cache hits → count rises to 4 by cycle 4. o_pc_next then holds at 0x110. Raise ready → head 0x100 pops; push resumes one cycle after count<4.
- i_cache_valid=0 for 5 cycles at PC 0x200 → o_pc_next stays 0x200 and count unchanged. When valid returns, the entry with PC 0x200 is enqueued exactly once.
- Redirect to 0x3FF while count=3 and a push is pending → next cycle count=0, o_inst_valid=0, o_pc_current=0x3FC. The pending instruction is absent from the FIFO.
- Same-cycle push and pop at count=2 over 20 cycles → count stays 2 and FIFO order is preserved across pointer wrap.
- pc_current = 2^26-4 with a hit → next o_pc_current = 0. The entry's PC = 0x3FFFFFC.
